// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transfer-path arbiter.
//   state_t  : sequencer states
//   RW_READ  : direction code for a read transfer (1)
//   RW_WRITE : direction code for a write transfer (0)
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_WFIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker.
// Searches the request vector starting at last_winner+1 and wrapping, and
// returns the first requester found.
//   req         in  NUM_MASTERS  request vector
//   last_winner in  IDX_W        index of the previously served master
//   winner      out NUM_MASTERS  one-hot winner (all zero when req is zero)
//   winner_idx  out IDX_W        index of the winner (0 when req is zero)
module uart_arb_rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_winner,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_W-1:0]       winner_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    int               pos;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      pos = int'(last_winner) + k;
      if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Sequencer/arbiter for the shared UART transfer path.
// Grants the path to one master at a time (round-robin), launches the
// transfer, counts words, waits for the memory write-finish on writes and
// returns a per-master done pulse.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to enable the stall timer
// that raises bus_error; without it bus_error is tied low.
//   clk, resetn            clock, asynchronous active-low reset
//   req/req_rw/req_words   per-master request, direction, word count
//   grant                  one-hot grant
//   rw, word_number        latched direction / word count (held until next grant)
//   xfer_start             one-cycle launch pulse, one cycle after grant
//   word_done, xfer_stop   per-word progress / early stop from the UART path
//   mem_write_finish       memory write complete (writes only)
//   done, bus_error, busy  completion pulse, watchdog pulse, not-idle flag
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int WORD_CNT_W     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_MASTERS-1:0]          req,
  input  logic [NUM_MASTERS-1:0]          req_rw,
  input  logic [NUM_MASTERS*WORD_CNT_W-1:0] req_words,
  output logic [NUM_MASTERS-1:0]          grant,
  output logic                            rw,
  output logic [WORD_CNT_W-1:0]           word_number,
  output logic                            xfer_start,
  input  logic                            word_done,
  input  logic                            xfer_stop,
  input  logic                            mem_write_finish,
  output logic [NUM_MASTERS-1:0]          done,
  output logic                            bus_error,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [WORD_CNT_W-1:0] CNT_ONE = WORD_CNT_W'(1);
  localparam logic [WORD_CNT_W-1:0] CNT_MAX = '1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_bus_arbiter: unsupported parameter values");
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   rw_q, rw_d;
  logic [WORD_CNT_W-1:0]  wn_q, wn_d;
  logic [WORD_CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   xs_q, xs_d;

  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic [WORD_CNT_W-1:0]  sel_words;
  logic                   sel_rw;
  logic                   wd_expire;

  uart_arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req        (req),
    .last_winner(last_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  // Mux the winning master's direction and word count.
  always_comb begin
    sel_words = '0;
    sel_rw    = RW_WRITE;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_words = req_words[k*WORD_CNT_W +: WORD_CNT_W];
        sel_rw    = req_rw[k];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Stall timer: restarts on launch and on any progress event, counts
  // only while a transfer is outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q <= '0;
    end else if (state_q == S_START || word_done || mem_write_finish) begin
      wd_q <= '0;
    end else if (state_q == S_XFER || state_q == S_WFIN) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign bus_error = (state_q == S_ERR);
`else
  assign wd_expire = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      rw_q    <= RW_WRITE;
      wn_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      xs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      wn_q    <= wn_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      xs_q    <= xs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rw_d    = rw_q;
    wn_d    = wn_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    xs_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = pick_idx;
          rw_d    = sel_rw;
          wn_d    = sel_words;
          grant_d = pick_onehot;
          state_d = (sel_words == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        xs_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (word_done && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        // Stop outranks the last-word decision so a stopped write skips WFIN.
        if (xfer_stop) begin
          state_d = S_DONE;
        end else if (word_done && cnt_q == wn_q - CNT_ONE) begin
          state_d = (rw_q == RW_READ) ? S_DONE : S_WFIN;
        end else if (!word_done && wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_WFIN: begin
        if (mem_write_finish) state_d = S_DONE;
        else if (wd_expire)   state_d = S_ERR;
      end
      S_DONE, S_ERR: begin
        grant_d = '0;
        last_d  = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign rw          = rw_q;
  assign word_number = wn_q;
  assign xfer_start  = xs_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE || state_q == S_ERR)
                       ? (NUM_MASTERS'(1) << idx_q) : '0;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
module tb_uart_bus_arbiter;

  localparam int NM = 2;
  localparam int WW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NM-1:0] req = '0;
  logic [NM-1:0] req_rw = '0;
  logic [NM*WW-1:0] req_words = '0;
  logic [NM-1:0] grant;
  logic          rw;
  logic [WW-1:0] word_number;
  logic          xfer_start;
  logic          word_done = 1'b0;
  logic          xfer_stop = 1'b0;
  logic          mem_write_finish = 1'b0;
  logic [NM-1:0] done;
  logic          bus_error;
  logic          busy;

  int checks = 0;
  int errors = 0;

  uart_bus_arbiter #(
    .NUM_MASTERS(NM), .WORD_CNT_W(WW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_rw(req_rw),
    .req_words(req_words), .grant(grant), .rw(rw),
    .word_number(word_number), .xfer_start(xfer_start),
    .word_done(word_done), .xfer_stop(xfer_stop),
    .mem_write_finish(mem_write_finish), .done(done),
    .bus_error(bus_error), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({grant, done, xfer_start, bus_error, busy, rw, word_number} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b done=%b xs=%b be=%b busy=%b rw=%b wn=%0d expected all zero",
               grant, done, xfer_start, bus_error, busy, rw, word_number);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_read;
    req = 2'b01; req_rw = 2'b01; req_words = {8'd0, 8'd4};
    tick();
    checks++;
    if (grant !== 2'b01 || xfer_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_grant: got grant=%b xs=%b busy=%b expected 01 0 1", grant, xfer_start, busy);
    end
    checks++;
    if (rw !== 1'b1 || word_number !== 8'd4) begin
      errors++;
      $display("FAIL read_latch: got rw=%b wn=%0d expected 1 4", rw, word_number);
    end
    tick();
    checks++;
    if (xfer_start !== 1'b1) begin
      errors++;
      $display("FAIL read_xfer_start: got %b expected 1", xfer_start);
    end
    word_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (done !== 2'b00 || xfer_start !== 1'b0) begin
      errors++;
      $display("FAIL read_early_done: got done=%b xs=%b expected 00 0", done, xfer_start);
    end
    tick();
    word_done = 1'b0;
    checks++;
    if (done !== 2'b01) begin
      errors++;
      $display("FAIL read_done: got %b expected 01", done);
    end
    req = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || word_number !== 8'd4 || rw !== 1'b1) begin
      errors++;
      $display("FAIL read_idle: got grant=%b done=%b busy=%b wn=%0d rw=%b expected 00 00 0 4 1",
               grant, done, busy, word_number, rw);
    end
  endtask

  task automatic test_write_wfin;
    req = 2'b10; req_rw = 2'b00; req_words = {8'd2, 8'd0};
    tick();
    checks++;
    if (grant !== 2'b10 || rw !== 1'b0 || word_number !== 8'd2) begin
      errors++;
      $display("FAIL write_grant: got grant=%b rw=%b wn=%0d expected 10 0 2", grant, rw, word_number);
    end
    tick();
    word_done = 1'b1;
    tick();
    tick();
    word_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (done !== 2'b00 || grant !== 2'b10 || busy !== 1'b1) begin
        errors++;
        $display("FAIL write_wfin_hold%0d: got done=%b grant=%b busy=%b expected 00 10 1", i, done, grant, busy);
      end
      tick();
    end
    mem_write_finish = 1'b1;
    tick();
    mem_write_finish = 1'b0;
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL write_done: got %b expected 10", done);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [NM-1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    req = 2'b11; req_rw = 2'b11; req_words = {8'd1, 8'd1};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b expected %b", i, grant, exp_g[i]);
      end
      tick();
      word_done = 1'b1;
      tick();
      word_done = 1'b0;
      checks++;
      if (done !== exp_g[i]) begin
        errors++;
        $display("FAIL rr_done%0d: got %b expected %b", i, done, exp_g[i]);
      end
      tick();
      checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: got grant=%b busy=%b expected 00 0", i, grant, busy);
      end
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_xfer_stop;
    req = 2'b01; req_rw = 2'b01; req_words = {8'd0, 8'd8};
    tick();
    tick();
    word_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    word_done = 1'b0;
    xfer_stop = 1'b1;
    checks++;
    if (done !== 2'b00) begin
      errors++;
      $display("FAIL stop_pre: got done=%b expected 00", done);
    end
    tick();
    xfer_stop = 1'b0;
    checks++;
    if (done !== 2'b01 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL stop_done: got done=%b be=%b expected 01 0", done, bus_error);
    end
    req = 2'b00;
    tick();
    // Write whose last word coincides with stop: done without waiting in WFIN.
    req = 2'b10; req_rw = 2'b00; req_words = {8'd2, 8'd0};
    tick();
    tick();
    word_done = 1'b1;
    tick();
    xfer_stop = 1'b1;
    tick();
    word_done = 1'b0; xfer_stop = 1'b0;
    checks++;
    if (done !== 2'b10) begin
      errors++;
      $display("FAIL stop_write_same_cycle: got done=%b expected 10", done);
    end
    req = 2'b00;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_write_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_zero_words;
    req = 2'b01; req_rw = 2'b01; req_words = {8'd5, 8'd0};
    tick();
    checks++;
    if (grant !== 2'b01 || done !== 2'b01 || xfer_start !== 1'b0 || word_number !== 8'd0) begin
      errors++;
      $display("FAIL zero_done: got grant=%b done=%b xs=%b wn=%0d expected 01 01 0 0",
               grant, done, xfer_start, word_number);
    end
    req = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || xfer_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got grant=%b done=%b xs=%b expected 00 00 0", grant, done, xfer_start);
    end
  endtask

  task automatic test_reset_mid;
    req = 2'b10; req_rw = 2'b10; req_words = {8'd4, 8'd0};
    tick();
    tick();
    word_done = 1'b1;
    tick();
    word_done = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || done !== 2'b00 || word_number !== 8'd0 || rw !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got grant=%b busy=%b done=%b wn=%0d rw=%b expected 00 0 00 0 0",
               grant, busy, done, word_number, rw);
    end
    req = 2'b00;
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after%0d: got done=%b busy=%b expected 00 0", i, done, busy);
      end
    end
    // After reset master 0 has priority again.
    req = 2'b11; req_rw = 2'b11; req_words = {8'd0, 8'd0};
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL reset_priority: got %b expected 01", grant);
    end
    req = 2'b00;
    tick();
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    req = 2'b01; req_rw = 2'b00; req_words = {8'd0, 8'd4};
    tick();
    tick();
    word_done = 1'b1;
    tick();
    word_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus_error !== 1'b0 || done !== 2'b00) begin
        errors++;
        $display("FAIL timeout_early%0d: got be=%b done=%b expected 0 00", i, bus_error, done);
      end
    end
    tick();
    checks++;
    if (bus_error !== 1'b1 || done !== 2'b01) begin
      errors++;
      $display("FAIL timeout_fire: got be=%b done=%b expected 1 01", bus_error, done);
    end
    req = 2'b00;
    tick();
    checks++;
    if (bus_error !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL timeout_idle: got be=%b busy=%b done=%b expected 0 0 00", bus_error, busy, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_wfin();
    test_back_to_back();
    test_xfer_stop();
    test_zero_words();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
